// File: rtl/mem_stage.sv
// Memory-access stage: EXE/MEM and MEM/WB registers around a word-addressed
// data memory whose accesses take a programmable number of wait states.
module mem_stage #(
    parameter int ADDR_W      = 8,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        exe_valid,
    input  logic [31:0] exe_result,
    input  logic [31:0] exe_store_data,
    input  logic [4:0]  exe_rd,
    input  logic        exe_wreg,
    input  logic        exe_m2reg,
    input  logic        exe_wmem,
    output logic        mem_stall,
    output logic [31:0] mem_data_forward,
    output logic [4:0]  mem_rd,
    output logic        mem_wreg,
    output logic [31:0] wb_data,
    output logic [4:0]  wb_rd,
    output logic        wb_wreg,
    output logic        wb_valid
);

    typedef struct packed {
        logic        valid;
        logic [31:0] result;
        logic [31:0] store_data;
        logic [4:0]  rd;
        logic        wreg;
        logic        m2reg;
        logic        wmem;
    } exe_mem_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] data;
        logic [4:0]  rd;
        logic        wreg;
    } mem_wb_t;

    localparam logic [1:0] WAIT_INIT = 2'(WAIT_CYCLES);

    exe_mem_t          em;
    exe_mem_t          em_next;
    mem_wb_t           mw;
    mem_wb_t           mw_next;
    logic [1:0]        cnt;
    logic              stall;
    logic              mem_op_in;
    logic              store_fire;
    logic [ADDR_W-1:0] word_addr;
    logic [31:0]       load_word;

    logic [31:0] dmem [2**ADDR_W];

    assign stall      = (cnt != 2'd0);
    assign mem_op_in  = exe_valid & (exe_m2reg | exe_wmem);
    assign word_addr  = em.result[ADDR_W+1:2];
    assign load_word  = dmem[word_addr];
    assign store_fire = resetn & ~stall & em.valid & em.wmem;

    always_comb begin
        em_next            = em;
        em_next.valid      = exe_valid;
        em_next.result     = exe_result;
        em_next.store_data = exe_store_data;
        em_next.rd         = exe_rd;
        em_next.wreg       = exe_wreg;
        em_next.m2reg      = exe_m2reg;
        em_next.wmem       = exe_wmem;
    end

    // Stalled cycles emit a bubble but keep data/rd so WB stays quiet.
    always_comb begin
        mw_next = mw;
        if (stall) begin
            mw_next.valid = 1'b0;
            mw_next.wreg  = 1'b0;
        end else begin
            mw_next.valid = em.valid;
            mw_next.rd    = em.rd;
            mw_next.wreg  = em.valid & em.wreg & ~em.wmem;
            mw_next.data  = em.m2reg ? load_word : em.result;
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            em  <= '0;
            mw  <= '0;
            cnt <= 2'd0;
        end else begin
            mw <= mw_next;
            if (stall) begin
                cnt <= cnt - 2'd1;
            end else begin
                em  <= em_next;
                cnt <= mem_op_in ? WAIT_INIT : 2'd0;
            end
        end
    end

    // Array is deliberately not reset; a store commits only on its last cycle.
    always_ff @(posedge clock) begin
        if (store_fire) begin
            dmem[word_addr] <= em.store_data;
        end
    end

    assign mem_stall        = stall;
    assign mem_data_forward = em.result;
    assign mem_rd           = em.rd;
    assign mem_wreg         = em.valid & em.wreg & ~em.wmem;
    assign wb_data          = mw.data;
    assign wb_rd            = mw.rd;
    assign wb_wreg          = mw.wreg;
    assign wb_valid         = mw.valid;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: one instance per wait-state count 0..3,
// a vector table for the zero-wait pipeline plus multi-cycle sequences.
module tb_mem_stage;

    localparam int N = 4;

    logic        clock;
    logic        resetn         [N];
    logic        exe_valid      [N];
    logic [31:0] exe_result     [N];
    logic [31:0] exe_store_data [N];
    logic [4:0]  exe_rd         [N];
    logic        exe_wreg       [N];
    logic        exe_m2reg      [N];
    logic        exe_wmem       [N];
    logic        mem_stall      [N];
    logic [31:0] mem_data_forward [N];
    logic [4:0]  mem_rd         [N];
    logic        mem_wreg       [N];
    logic [31:0] wb_data        [N];
    logic [4:0]  wb_rd          [N];
    logic        wb_wreg        [N];
    logic        wb_valid       [N];

    int checks;
    int failures;

    for (genvar w = 0; w < N; w++) begin : g_dut
        mem_stage #(.ADDR_W(8), .WAIT_CYCLES(w)) dut (
            .clock           (clock),
            .resetn          (resetn[w]),
            .exe_valid       (exe_valid[w]),
            .exe_result      (exe_result[w]),
            .exe_store_data  (exe_store_data[w]),
            .exe_rd          (exe_rd[w]),
            .exe_wreg        (exe_wreg[w]),
            .exe_m2reg       (exe_m2reg[w]),
            .exe_wmem        (exe_wmem[w]),
            .mem_stall       (mem_stall[w]),
            .mem_data_forward(mem_data_forward[w]),
            .mem_rd          (mem_rd[w]),
            .mem_wreg        (mem_wreg[w]),
            .wb_data         (wb_data[w]),
            .wb_rd           (wb_rd[w]),
            .wb_wreg         (wb_wreg[w]),
            .wb_valid        (wb_valid[w])
        );
    end

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        bit        v;
        bit [31:0] res;
        bit [31:0] sd;
        bit [4:0]  rd;
        bit        wreg;
        bit        m2r;
        bit        wmem;
        bit        x_stall;
        bit [31:0] x_fwd;
        bit [4:0]  x_mrd;
        bit        x_mwreg;
        bit [31:0] x_wbd;
        bit [4:0]  x_wbrd;
        bit        x_wbw;
        bit        x_wbv;
    } vec_t;

    vec_t vec [6];

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input int k, input bit v, input bit [31:0] res,
                         input bit [31:0] sd, input bit [4:0] rd,
                         input bit wreg, input bit m2r, input bit wmem);
        exe_valid[k]      = v;
        exe_result[k]     = res;
        exe_store_data[k] = sd;
        exe_rd[k]         = rd;
        exe_wreg[k]       = wreg;
        exe_m2reg[k]      = m2r;
        exe_wmem[k]       = wmem;
    endtask

    task automatic idle(input int k);
        drive(k, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic chk_stall(input int k, input string name, input bit exp);
        chk($sformatf("%s.stall[%0d]", name, k), 32'(mem_stall[k]), 32'(exp));
    endtask

    task automatic chk_wb(input int k, input string name, input bit v,
                          input bit w, input bit [31:0] d, input bit [4:0] rd);
        chk($sformatf("%s.wb_valid[%0d]", name, k), 32'(wb_valid[k]), 32'(v));
        chk($sformatf("%s.wb_wreg[%0d]", name, k), 32'(wb_wreg[k]), 32'(w));
        chk($sformatf("%s.wb_data[%0d]", name, k), wb_data[k], d);
        chk($sformatf("%s.wb_rd[%0d]", name, k), 32'(wb_rd[k]), 32'(rd));
    endtask

    task automatic chk_all(input int k, input string name, input bit st,
                           input bit [31:0] fwd, input bit [4:0] mrd,
                           input bit mw, input bit [31:0] d,
                           input bit [4:0] rd, input bit w, input bit v);
        chk_stall(k, name, st);
        chk($sformatf("%s.fwd[%0d]", name, k), mem_data_forward[k], fwd);
        chk($sformatf("%s.mem_rd[%0d]", name, k), 32'(mem_rd[k]), 32'(mrd));
        chk($sformatf("%s.mem_wreg[%0d]", name, k), 32'(mem_wreg[k]), 32'(mw));
        chk_wb(k, name, v, w, d, rd);
    endtask

    initial begin
        checks   = 0;
        failures = 0;

        vec[0] = '{1, 32'h1234, 0, 5, 1, 0, 0,
                   0, 32'h1234, 5, 1, 32'h0, 0, 0, 0};
        vec[1] = '{1, 32'h40, 32'hCAFEF00D, 0, 0, 0, 1,
                   0, 32'h40, 0, 0, 32'h1234, 5, 1, 1};
        vec[2] = '{1, 32'h40, 0, 7, 1, 1, 0,
                   0, 32'h40, 7, 1, 32'h40, 0, 0, 1};
        vec[3] = '{0, 32'h99, 0, 3, 1, 0, 0,
                   0, 32'h99, 3, 0, 32'hCAFEF00D, 7, 1, 1};
        vec[4] = '{1, 32'hFFFFFFFF, 0, 31, 1, 0, 0,
                   0, 32'hFFFFFFFF, 31, 1, 32'h99, 3, 0, 0};
        vec[5] = '{0, 0, 0, 0, 0, 0, 0,
                   0, 32'h0, 0, 0, 32'hFFFFFFFF, 31, 1, 1};

        // Reset held three edges with a store presented on every instance.
        for (int k = 0; k < N; k++) begin
            resetn[k] = 1'b0;
            drive(k, 1'b1, 32'h80, 32'h5555, 5'd3, 1'b1, 1'b0, 1'b1);
        end
        repeat (3) tick();
        for (int k = 0; k < N; k++) begin
            chk_all(k, "reset", 0, 0, 0, 0, 0, 0, 0, 0);
            resetn[k] = 1'b1;
            idle(k);
        end
        tick();

        // Zero-wait pipeline table on instance 0.
        for (int i = 0; i < 6; i++) begin
            drive(0, vec[i].v, vec[i].res, vec[i].sd, vec[i].rd,
                  vec[i].wreg, vec[i].m2r, vec[i].wmem);
            tick();
            chk_all(0, $sformatf("vec%0d", i), vec[i].x_stall, vec[i].x_fwd,
                    vec[i].x_mrd, vec[i].x_mwreg, vec[i].x_wbd,
                    vec[i].x_wbrd, vec[i].x_wbw, vec[i].x_wbv);
        end

        // Store held during reset must not reach memory.
        resetn[0] = 1'b0;
        drive(0, 1'b1, 32'h40, 32'h5555, 5'd2, 1'b0, 1'b0, 1'b1);
        repeat (3) tick();
        chk_all(0, "rst_store", 0, 0, 0, 0, 0, 0, 0, 0);
        resetn[0] = 1'b1;
        drive(0, 1'b1, 32'h43, 32'h0, 5'd8, 1'b1, 1'b1, 1'b0);
        tick();
        chk_stall(0, "rst_load", 0);
        idle(0);
        tick();
        chk_wb(0, "rst_load", 1, 1, 32'hCAFEF00D, 5'd8);

        // W=1 ALU pass-through.
        drive(1, 1'b1, 32'h1234, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0);
        tick();
        chk_stall(1, "alu", 0);
        chk("alu.fwd", mem_data_forward[1], 32'h1234);
        idle(1);
        tick();
        chk_stall(1, "alu2", 0);
        chk_wb(1, "alu", 1, 1, 32'h1234, 5'd5);

        // W=1 store (with wreg set) then load of the same word.
        drive(1, 1'b1, 32'h10, 32'hDEADBEEF, 5'd4, 1'b1, 1'b0, 1'b1);
        tick();
        chk_stall(1, "st_w1", 1);
        tick();
        chk_stall(1, "st_done", 0);
        drive(1, 1'b1, 32'h13, 32'h0, 5'd6, 1'b1, 1'b1, 1'b0);
        tick();
        chk_stall(1, "ld_w1", 1);
        chk("st.wb_valid", 32'(wb_valid[1]), 32'd1);
        chk("st.wb_wreg", 32'(wb_wreg[1]), 32'd0);
        tick();
        chk_stall(1, "ld_done", 0);
        chk("ld.bubble", 32'(wb_valid[1]), 32'd0);
        idle(1);
        tick();
        chk_wb(1, "ld_w1", 1, 1, 32'hDEADBEEF, 5'd6);

        // W=2: preload two words, then back-to-back loads.
        drive(2, 1'b1, 32'h10, 32'h11111111, 5'd0, 1'b0, 1'b0, 1'b1);
        repeat (3) tick();
        drive(2, 1'b1, 32'h14, 32'h22222222, 5'd0, 1'b0, 1'b0, 1'b1);
        repeat (3) tick();
        drive(2, 1'b1, 32'h10, 32'h0, 5'd1, 1'b1, 1'b1, 1'b0);
        tick();
        chk_stall(2, "b2b_a1", 1);
        tick();
        chk_stall(2, "b2b_a2", 1);
        tick();
        chk_stall(2, "b2b_a3", 0);
        drive(2, 1'b1, 32'h14, 32'h0, 5'd2, 1'b1, 1'b1, 1'b0);
        tick();
        chk_stall(2, "b2b_b1", 1);
        chk_wb(2, "b2b_a", 1, 1, 32'h11111111, 5'd1);
        tick();
        chk_stall(2, "b2b_b2", 1);
        chk("b2b.bub1", 32'(wb_valid[2]), 32'd0);
        tick();
        chk_stall(2, "b2b_b3", 0);
        chk("b2b.bub2", 32'(wb_valid[2]), 32'd0);
        idle(2);
        tick();
        chk_wb(2, "b2b_b", 1, 1, 32'h22222222, 5'd2);

        // W=3: reset in the second stall cycle aborts the pending store.
        drive(3, 1'b1, 32'h20, 32'h1, 5'd0, 1'b0, 1'b0, 1'b1);
        repeat (4) tick();
        chk_stall(3, "pre_done", 0);
        idle(3);
        tick();
        drive(3, 1'b1, 32'h20, 32'h2, 5'd0, 1'b0, 1'b0, 1'b1);
        tick();
        chk_stall(3, "abort_s1", 1);
        tick();
        chk_stall(3, "abort_s2", 1);
        resetn[3] = 1'b0;
        tick();
        chk_all(3, "abort_rst", 0, 0, 0, 0, 0, 0, 0, 0);
        resetn[3] = 1'b1;
        idle(3);
        tick();
        drive(3, 1'b1, 32'h20, 32'h0, 5'd2, 1'b1, 1'b1, 1'b0);
        repeat (3) tick();
        chk_stall(3, "abort_ld", 1);
        tick();
        chk_stall(3, "abort_ld_done", 0);
        idle(3);
        tick();
        chk_wb(3, "abort_ld", 1, 1, 32'h1, 5'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
